// File: rtl/tx_redundant_framer.sv
// Buffers one payload segment, then transmits it as N identical Ethernet/IPv4/UDP frames,
// each carrying a 4-byte tag (segment number, copy index, aux) and a CRC-32 FCS.
module tx_redundant_framer #(
  parameter int          PAYLOAD_LEN = 1440,
  parameter logic [47:0] DST_MAC     = 48'hDEADBEEF0123,
  parameter logic [47:0] SRC_MAC     = 48'h00183E000001,
  parameter logic [31:0] SRC_IP      = 32'hC0A80140,
  parameter logic [31:0] DST_IP      = 32'hC0A80101,
  parameter logic [15:0] IP_CSUM     = 16'h0000,
  parameter int          GAP_CYCLES  = 12
) (
  input  logic        clk125MHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic [15:0] seg_num,
  input  logic [7:0]  aux,
  input  logic [7:0]  redundancy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        done
);

  localparam int          AW       = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [15:0] PL16     = 16'(PAYLOAD_LEN);
  localparam logic [15:0] PAY_END  = 16'(PAYLOAD_LEN + 53);
  localparam logic [15:0] FCS_BASE = 16'(PAYLOAD_LEN + 54);
  localparam logic [15:0] FCS_END  = 16'(PAYLOAD_LEN + 57);
  localparam logic [15:0] GAP_END  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] IP_LEN   = 16'(PAYLOAD_LEN + 32);
  localparam logic [15:0] UDP_LEN  = 16'(PAYLOAD_LEN + 12);
  // Stream bytes 8..49, first byte in the top octet
  localparam logic [335:0] HDR = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, IP_LEN,
                                  48'h0000_4000_4011, IP_CSUM, SRC_IP, DST_IP,
                                  16'h1000, 16'h1000, UDP_LEN, 16'h0000};

  typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, HEADER, TAG, PAYLOAD, FCS, GAP} state_t;

  state_t      state, state_next;
  logic [15:0] idx;
  logic [15:0] wr_cnt;
  logic [7:0]  copy;
  logic        seg_end;
  logic        armed;
  logic [15:0] seg_q;
  logic [7:0]  aux_q;
  logic [7:0]  red_q;
  logic [31:0] crc;
  logic [7:0]  buffer [PAYLOAD_LEN];

  logic        accept;
  logic        last_copy;
  logic [7:0]  red_eff;
  logic [15:0] pidx;
  logic [5:0]  hoff;
  logic [1:0]  fsel;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign accept    = in_valid && in_ready;
  assign red_eff   = (red_q == 8'd0) ? 8'd1 : red_q;
  assign last_copy = ({1'b0, copy} + 9'd1) >= {1'b0, red_eff};
  assign busy      = (state != IDLE);
  assign in_ready  = armed && ((state == IDLE) ||
                               (state == LOAD && !seg_end && wr_cnt < PL16));

  always_ff @(posedge clk125MHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = LOAD;
      LOAD:     if (seg_end || wr_cnt >= PL16 ||
                    (accept && (in_last || wr_cnt == PL16 - 16'd1)))
                  state_next = PREAMBLE;
      PREAMBLE: if (idx == 16'd7)  state_next = HEADER;
      HEADER:   if (idx == 16'd49) state_next = TAG;
      TAG:      if (idx == 16'd53) state_next = PAYLOAD;
      PAYLOAD:  if (idx == PAY_END) state_next = FCS;
      FCS:      if (idx == FCS_END) state_next = GAP;
      GAP:      if (idx == GAP_END) state_next = last_copy ? IDLE : PREAMBLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_en   = 1'b0;
    tx_data = 8'h00;
    pidx    = idx - 16'd54;
    hoff    = 6'd49 - idx[5:0];
    fsel    = idx[1:0] - FCS_BASE[1:0];
    fcs     = ~crc;
    case (state)
      PREAMBLE: begin
        tx_en   = 1'b1;
        tx_data = (idx == 16'd7) ? 8'hD5 : 8'h55;
      end
      HEADER: begin
        tx_en   = 1'b1;
        tx_data = HDR[{hoff, 3'b000} +: 8];
      end
      TAG: begin
        tx_en = 1'b1;
        case (idx[1:0])
          2'b10:   tx_data = seg_q[15:8];
          2'b11:   tx_data = seg_q[7:0];
          2'b00:   tx_data = copy;
          default: tx_data = aux_q;
        endcase
      end
      PAYLOAD: begin
        // Bytes past the end of a short segment go out as zero padding
        tx_en   = 1'b1;
        tx_data = (pidx < wr_cnt) ? buffer[pidx[AW-1:0]] : 8'h00;
      end
      FCS: begin
        tx_en   = 1'b1;
        tx_data = fcs[{fsel, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      wr_cnt  <= '0;
      copy    <= '0;
      seg_end <= 1'b0;
      armed   <= 1'b0;
      done    <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= (state == GAP) && (idx == GAP_END) && last_copy;
      if ((state_next == PREAMBLE && state != PREAMBLE) || (state_next == GAP && state != GAP))
        idx <= '0;
      else if (state != IDLE && state != LOAD)
        idx <= idx + 16'd1;
      else
        idx <= '0;
      if (state == IDLE) begin
        copy <= '0;
        if (accept) begin
          wr_cnt  <= 16'd1;
          seg_end <= in_last;
        end
      end else if (state == LOAD && accept) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (state == GAP && idx == GAP_END) copy <= copy + 8'd1;
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (accept) buffer[(state == IDLE) ? '0 : wr_cnt[AW-1:0]] <= in_data;
    if (state == IDLE && accept) begin
      seg_q <= seg_num;
      aux_q <= aux;
      red_q <= redundancy;
    end
    if (state == PREAMBLE)
      crc <= 32'hFFFFFFFF;
    else if (state == HEADER || state == TAG || state == PAYLOAD)
      crc <= crc_next(crc, tx_data);
  end

endmodule

// File: tb/tb_tx_redundant_framer.sv
// Directed bench: a PAYLOAD_LEN=4 instance for the framing scenarios and a
// default-parameter instance for the full-size frame.
`timescale 1ns/1ps
module tb_tx_redundant_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 0, s_last = 0, s_ready;
  logic [7:0]  s_data = 0, s_aux = 0, s_red = 0, s_tx_data;
  logic [15:0] s_seg = 0;
  logic        s_tx_en, s_busy, s_done;
  logic        d_valid = 0, d_last = 0, d_ready;
  logic [7:0]  d_data = 0, d_aux = 0, d_red = 0, d_tx_data;
  logic [15:0] d_seg = 0;
  logic        d_tx_en, d_busy, d_done;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  frm[$];
  logic [7:0]  pl_q[$];
  logic [7:0]  exp_pl[$];
  int          gap_len;
  logic        done_seen;
  logic [7:0]  vpat = 8'b0110_1001;

  always #4 clk = ~clk;

  tx_redundant_framer #(.PAYLOAD_LEN(4)) dut_s (
    .clk125MHz(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .in_last(s_last), .seg_num(s_seg), .aux(s_aux),
    .redundancy(s_red), .tx_data(s_tx_data), .tx_en(s_tx_en), .busy(s_busy), .done(s_done));

  tx_redundant_framer dut_d (
    .clk125MHz(clk), .reset(reset), .in_valid(d_valid), .in_ready(d_ready),
    .in_data(d_data), .in_last(d_last), .seg_num(d_seg), .aux(d_aux),
    .redundancy(d_red), .tx_data(d_tx_data), .tx_en(d_tx_en), .busy(d_busy), .done(d_done));

  function automatic logic [7:0] exp_hdr(int i, int pl, logic [15:0] seg, logic [7:0] cp, logic [7:0] ax);
    logic [7:0]  h [54];
    logic [15:0] tl, ul;
    tl = 16'(pl + 32);
    ul = 16'(pl + 12);
    for (int k = 0; k < 7; k++) h[k] = 8'h55;
    h[7] = 8'hD5;
    h[8] = 8'hDE; h[9] = 8'hAD; h[10] = 8'hBE; h[11] = 8'hEF; h[12] = 8'h01; h[13] = 8'h23;
    h[14] = 8'h00; h[15] = 8'h18; h[16] = 8'h3E; h[17] = 8'h00; h[18] = 8'h00; h[19] = 8'h01;
    h[20] = 8'h08; h[21] = 8'h00; h[22] = 8'h45; h[23] = 8'h00; h[24] = tl[15:8]; h[25] = tl[7:0];
    h[26] = 8'h00; h[27] = 8'h00; h[28] = 8'h40; h[29] = 8'h00; h[30] = 8'h40; h[31] = 8'h11;
    h[32] = 8'h00; h[33] = 8'h00;
    h[34] = 8'hC0; h[35] = 8'hA8; h[36] = 8'h01; h[37] = 8'h40;
    h[38] = 8'hC0; h[39] = 8'hA8; h[40] = 8'h01; h[41] = 8'h01;
    h[42] = 8'h10; h[43] = 8'h00; h[44] = 8'h10; h[45] = 8'h00; h[46] = ul[15:8]; h[47] = ul[7:0];
    h[48] = 8'h00; h[49] = 8'h00;
    h[50] = seg[15:8]; h[51] = seg[7:0]; h[52] = cp; h[53] = ax;
    return h[i];
  endfunction

  // CRC register after running over bytes 8..end including the FCS: a good frame leaves the Ethernet residue
  function automatic logic [31:0] resid();
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int i = 8; i < frm.size(); i++)
      for (int b = 0; b < 8; b++)
        r = (r[0] ^ frm[i][b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic int hdr_bad(int pl, logic [15:0] seg, logic [7:0] cp, logic [7:0] ax);
    int bad = 0;
    for (int i = 0; i < 54; i++)
      if (i >= frm.size() || frm[i] !== exp_hdr(i, pl, seg, cp, ax)) bad++;
    return bad;
  endfunction

  function automatic int pay_bad();
    int bad = 0;
    for (int i = 0; i < exp_pl.size(); i++)
      if (54 + i >= frm.size() || frm[54 + i] !== exp_pl[i]) bad++;
    return bad;
  endfunction

  task automatic capture(input bit sel, output int wait_cyc);
    frm.delete();
    wait_cyc = 0;
    gap_len = 0;
    while (!(sel ? d_tx_en : s_tx_en) && wait_cyc < 4000) begin @(negedge clk); wait_cyc++; end
    while ((sel ? d_tx_en : s_tx_en) && frm.size() < 2000) begin
      frm.push_back(sel ? d_tx_data : s_tx_data);
      @(negedge clk);
    end
    while (!(sel ? d_tx_en : s_tx_en) && !(sel ? d_done : s_done) && gap_len < 100) begin
      @(negedge clk);
      gap_len++;
    end
    done_seen = sel ? d_done : s_done;
  endtask

  task automatic send_s(input int last_at, input logic [15:0] seg, input logic [7:0] ax,
                        input logic [7:0] red, input bit toggle);
    int i = 0, cyc = 0, k = 0;
    s_seg = seg; s_aux = ax; s_red = red;
    while (i < pl_q.size() && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s_valid = toggle ? vpat[k % 8] : 1'b1;
      k++;
      s_data = s_valid ? pl_q[i] : 8'hEE;
      s_last = s_valid && (i == last_at);
      if (s_valid && s_ready) i++;
    end
    @(negedge clk);
    s_valid = 0; s_last = 0; s_data = 8'h99;
    s_seg = 16'hFFFF; s_aux = 8'h77; s_red = 8'd9;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A;
    repeat (3) @(negedge clk);
    n_checks++; if (s_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en got %b want 0", s_tx_en); end
    n_checks++; if (s_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %h want 00", s_tx_data); end
    n_checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done got %b%b want 00", s_busy, s_done); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", s_ready); end
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready got %b want 0", s_ready); end
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1 || s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_first_edge ready/busy got %b%b want 10", s_ready, s_busy); end
  endtask

  task automatic test_red3();
    int w;
    pl_q = {8'h11, 8'h22, 8'h33, 8'h44};
    exp_pl = {8'h11, 8'h22, 8'h33, 8'h44};
    send_s(3, 16'h0102, 8'hAA, 8'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      capture(1'b0, w);
      if (c == 0) begin
        n_checks++; if (w !== 0) begin n_fail++; $display("FAIL red3_latency got %0d want 0", w); end
      end
      n_checks++; if (frm.size() !== 62) begin n_fail++; $display("FAIL red3_len copy %0d got %0d want 62", c, frm.size()); end
      n_checks++; if (hdr_bad(4, 16'h0102, 8'(c), 8'hAA) !== 0) begin n_fail++; $display("FAIL red3_hdr copy %0d byte52 got %h want %h", c, frm[52], 8'(c)); end
      n_checks++; if (pay_bad() !== 0) begin n_fail++; $display("FAIL red3_payload copy %0d got %h%h%h%h want 11223344", c, frm[54], frm[55], frm[56], frm[57]); end
      n_checks++; if (resid() !== 32'hDEBB20E3) begin n_fail++; $display("FAIL red3_fcs copy %0d residue got %h want debb20e3", c, resid()); end
      n_checks++; if (gap_len !== 12) begin n_fail++; $display("FAIL red3_gap copy %0d got %0d want 12", c, gap_len); end
      n_checks++; if (done_seen !== (c == 2)) begin n_fail++; $display("FAIL red3_done copy %0d got %b want %b", c, done_seen, (c == 2)); end
    end
    @(negedge clk);
    n_checks++; if (s_done !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL red3_after done/busy/ready got %b%b%b want 001", s_done, s_busy, s_ready); end
  endtask

  task automatic test_short();
    int w;
    pl_q = {8'h11, 8'h22};
    exp_pl = {8'h11, 8'h22, 8'h00, 8'h00};
    send_s(1, 16'h0304, 8'h5A, 8'd1, 1'b0);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL short_ready got %b want 0", s_ready); end
    capture(1'b0, w);
    n_checks++; if (frm.size() !== 62) begin n_fail++; $display("FAIL short_len got %0d want 62", frm.size()); end
    n_checks++; if (pay_bad() !== 0) begin n_fail++; $display("FAIL short_payload got %h%h%h%h want 11220000", frm[54], frm[55], frm[56], frm[57]); end
    n_checks++; if (hdr_bad(4, 16'h0304, 8'h00, 8'h5A) !== 0) begin n_fail++; $display("FAIL short_hdr got %h%h want 0304", frm[50], frm[51]); end
    n_checks++; if (resid() !== 32'hDEBB20E3) begin n_fail++; $display("FAIL short_fcs residue got %h want debb20e3", resid()); end
    @(negedge clk);
  endtask

  task automatic test_red0();
    int w, extra;
    pl_q = {8'h01, 8'h02, 8'h03, 8'h04};
    exp_pl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_s(3, 16'h0A0B, 8'hC3, 8'd0, 1'b0);
    capture(1'b0, w);
    n_checks++; if (frm.size() !== 62 || frm[52] !== 8'h00) begin n_fail++; $display("FAIL red0_frame len %0d copy %h want 62 00", frm.size(), frm[52]); end
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL red0_done got %b want 1", done_seen); end
    extra = 0;
    repeat (20) begin @(negedge clk); if (s_tx_en) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL red0_extra_frame tx_en cycles got %0d want 0", extra); end
  endtask

  task automatic test_valid_toggle();
    int w;
    pl_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_pl = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_s(3, 16'h0506, 8'h3C, 8'd1, 1'b1);
    capture(1'b0, w);
    n_checks++; if (pay_bad() !== 0) begin n_fail++; $display("FAIL toggle_payload got %h%h%h%h want a1b2c3d4", frm[54], frm[55], frm[56], frm[57]); end
    n_checks++; if (hdr_bad(4, 16'h0506, 8'h00, 8'h3C) !== 0) begin n_fail++; $display("FAIL toggle_hdr got %h%h want 0506", frm[50], frm[51]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w;
    pl_q = {8'h21, 8'h43, 8'h65, 8'h87};
    exp_pl = {8'h21, 8'h43, 8'h65, 8'h87};
    send_s(3, 16'h0708, 8'h11, 8'd2, 1'b0);
    capture(1'b0, w);
    repeat (30) @(negedge clk);
    n_checks++; if (s_tx_en !== 1'b1 || s_tx_data !== 8'h40 || s_busy !== 1'b1) begin n_fail++; $display("FAIL mid_index30 en/data/busy got %b %h %b want 1 40 1", s_tx_en, s_tx_data, s_busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (s_tx_en !== 1'b0 || s_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_tx got %b %h want 0 00", s_tx_en, s_tx_data); end
    n_checks++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl busy/done/ready got %b%b%b want 000", s_busy, s_done, s_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pl_q = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_pl = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_s(3, 16'h090A, 8'h22, 8'd1, 1'b0);
    capture(1'b0, w);
    n_checks++; if (frm.size() !== 62 || hdr_bad(4, 16'h090A, 8'h00, 8'h22) !== 0) begin n_fail++; $display("FAIL mid_reload len %0d copy %h want 62 00", frm.size(), frm[52]); end
    n_checks++; if (pay_bad() !== 0 || resid() !== 32'hDEBB20E3) begin n_fail++; $display("FAIL mid_reload_body payload0 %h residue %h want 9a debb20e3", frm[54], resid()); end
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done got %b want 1", done_seen); end
    @(negedge clk);
  endtask

  task automatic test_red255();
    int w, bad, early;
    pl_q = {8'h55, 8'h66, 8'h77, 8'h88};
    send_s(3, 16'hFFEE, 8'h01, 8'd255, 1'b0);
    bad = 0;
    early = 0;
    for (int c = 0; c < 255; c++) begin
      capture(1'b0, w);
      if (frm.size() != 62 || frm[52] !== 8'(c) || gap_len != 12) bad++;
      if (c < 254 && done_seen) early++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL red255_frames bad frames got %0d want 0", bad); end
    n_checks++; if (early !== 0 || done_seen !== 1'b1) begin n_fail++; $display("FAIL red255_done early %0d final %b want 0 1", early, done_seen); end
    @(negedge clk);
  endtask

  task automatic test_defaults();
    int w, cyc;
    int i = 0;
    exp_pl.delete();
    for (int k = 0; k < 1440; k++) exp_pl.push_back(8'(k) ^ 8'h5A);
    d_seg = 16'hBEEF; d_aux = 8'h33; d_red = 8'd1;
    cyc = 0;
    while (i < 1440 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      d_valid = 1'b1;
      d_data = exp_pl[i];
      d_last = (i == 1439);
      if (d_ready) i++;
    end
    @(negedge clk);
    d_valid = 0; d_last = 0;
    capture(1'b1, w);
    n_checks++; if (frm.size() !== 1498) begin n_fail++; $display("FAIL def_len got %0d want 1498", frm.size()); end
    n_checks++; if (frm[8] !== 8'hDE || frm[9] !== 8'hAD || frm[13] !== 8'h23) begin n_fail++; $display("FAIL def_dst_mac got %h%h..%h want dead..23", frm[8], frm[9], frm[13]); end
    n_checks++; if ({frm[34], frm[35], frm[36], frm[37]} !== 32'hC0A80140) begin n_fail++; $display("FAIL def_src_ip got %h%h%h%h want c0a80140", frm[34], frm[35], frm[36], frm[37]); end
    n_checks++; if ({frm[24], frm[25], frm[46], frm[47]} !== 32'h05C005AC) begin n_fail++; $display("FAIL def_lengths got %h%h %h%h want 05c0 05ac", frm[24], frm[25], frm[46], frm[47]); end
    n_checks++; if (hdr_bad(1440, 16'hBEEF, 8'h00, 8'h33) !== 0) begin n_fail++; $display("FAIL def_hdr seg got %h%h want beef", frm[50], frm[51]); end
    n_checks++; if (pay_bad() !== 0) begin n_fail++; $display("FAIL def_payload mismatching bytes %0d want 0", pay_bad()); end
    n_checks++; if (resid() !== 32'hDEBB20E3) begin n_fail++; $display("FAIL def_fcs residue got %h want debb20e3", resid()); end
    n_checks++; if (gap_len !== 12 || done_seen !== 1'b1) begin n_fail++; $display("FAIL def_gap_done got %0d %b want 12 1", gap_len, done_seen); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_red3();
    test_short();
    test_red0();
    test_valid_toggle();
    test_reset_mid();
    test_red255();
    test_defaults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
